// File: rtl/shared_resource_client_if.sv
// ============================================================================
// shared_resource_client_if : upstream / port / downstream bundle    Rev 1.0
// ============================================================================
`default_nettype none

interface shared_resource_client_if #(
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic              up_valid;
    logic [DATA_W-1:0] up_data;
    logic              up_ready;
    logic              flush_req;
    logic              req_valid;
    logic [DATA_W-1:0] req_data;
    logic              req_flush;
    logic              req_stall;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_stall;
    logic              dn_valid;
    logic [DATA_W-1:0] dn_data;
    logic              dn_ready;
    logic [CNT_W-1:0]  outstanding;
    logic              busy;

    // Environment side: local pipeline, arbitration port and downstream consumer.
    modport master (
        output up_valid, up_data, flush_req, req_stall, rsp_valid, rsp_data, dn_ready,
        input  up_ready, req_valid, req_data, req_flush, rsp_stall, dn_valid, dn_data,
               outstanding, busy
    );

    modport slave (
        input  up_valid, up_data, flush_req, req_stall, rsp_valid, rsp_data, dn_ready,
        output up_ready, req_valid, req_data, req_flush, rsp_stall, dn_valid, dn_data,
               outstanding, busy
    );
endinterface

`default_nettype wire

// File: rtl/shared_resource_client.sv
// ============================================================================
// shared_resource_client : skid-buffered requester with result FIFO  Rev 1.0
// ============================================================================
`default_nettype none

module shared_resource_client #(
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RQ_DEPTH        = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    shared_resource_client_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int RQ_AW = $clog2(RQ_DEPTH);
    localparam int RQ_CW = RQ_AW + 1;
    localparam logic [CNT_W-1:0] OUT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [RQ_CW-1:0] RQ_FULL = RQ_CW'(RQ_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   st_idle, st_flush;

    logic [DATA_W-1:0] skid_mem_q [2];
    logic              skid_rd_q, skid_wr_q;
    logic [1:0]        skid_cnt_q;

    logic [DATA_W-1:0] rq_mem_q [RQ_DEPTH];
    logic [RQ_AW-1:0]  rq_rd_q, rq_wr_q;
    logic [RQ_CW-1:0]  rq_cnt_q;

    logic [CNT_W-1:0]  out_cnt_q;

    logic up_ready, req_valid, issue, skid_push;
    logic rsp_stall, rsp_acc, rq_push, rq_pop, dn_valid;

    always_comb begin
        state_d  = state_q;
        st_idle  = 1'b0;
        st_flush = 1'b0;
        case (state_q)
            ST_IDLE:   st_idle = 1'b1;
            ST_FLUSH: begin
                st_flush = 1'b1;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (bus.flush_req) begin
            state_d = ST_FLUSH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An op offered in the same cycle as flush_req is refused rather than swallowed.
    assign up_ready  = st_idle & (skid_cnt_q != 2'd2) & ~bus.flush_req;
    assign skid_push = bus.up_valid & up_ready;
    assign req_valid = st_idle & (skid_cnt_q != 2'd0) & (out_cnt_q < OUT_MAX);
    assign issue     = req_valid & ~bus.req_stall;

    assign rsp_stall = st_idle & (rq_cnt_q == RQ_FULL);
    assign rsp_acc   = bus.rsp_valid & ~rsp_stall & st_idle;
    assign rq_push   = rsp_acc & (out_cnt_q != '0);
    assign dn_valid  = (rq_cnt_q != '0);
    assign rq_pop    = dn_valid & bus.dn_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                skid_mem_q[i] <= '0;
            end
            skid_rd_q  <= 1'b0;
            skid_wr_q  <= 1'b0;
            skid_cnt_q <= 2'd0;
        end else if (st_flush) begin
            skid_rd_q  <= 1'b0;
            skid_wr_q  <= 1'b0;
            skid_cnt_q <= 2'd0;
        end else begin
            if (skid_push) begin
                skid_mem_q[skid_wr_q] <= bus.up_data;
                skid_wr_q             <= ~skid_wr_q;
            end
            if (issue) begin
                skid_rd_q <= ~skid_rd_q;
            end
            skid_cnt_q <= skid_cnt_q + {1'b0, skid_push} - {1'b0, issue};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_cnt_q <= '0;
        end else if (st_flush) begin
            out_cnt_q <= '0;
        end else begin
            case ({issue, rq_push})
                2'b10:   out_cnt_q <= out_cnt_q + 1'b1;
                2'b01:   out_cnt_q <= out_cnt_q - 1'b1;
                default: out_cnt_q <= out_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RQ_DEPTH; i++) begin
                rq_mem_q[i] <= '0;
            end
            rq_rd_q  <= '0;
            rq_wr_q  <= '0;
            rq_cnt_q <= '0;
        end else if (st_flush) begin
            rq_rd_q  <= '0;
            rq_wr_q  <= '0;
            rq_cnt_q <= '0;
        end else begin
            if (rq_push) begin
                rq_mem_q[rq_wr_q] <= bus.rsp_data;
                rq_wr_q           <= rq_wr_q + 1'b1;
            end
            if (rq_pop) begin
                rq_rd_q <= rq_rd_q + 1'b1;
            end
            rq_cnt_q <= rq_cnt_q + RQ_CW'(rq_push) - RQ_CW'(rq_pop);
        end
    end

    assign bus.up_ready    = up_ready;
    assign bus.req_valid   = req_valid;
    assign bus.req_data    = skid_mem_q[skid_rd_q];
    assign bus.req_flush   = st_flush;
    assign bus.rsp_stall   = rsp_stall;
    assign bus.dn_valid    = dn_valid;
    assign bus.dn_data     = rq_mem_q[rq_rd_q];
    assign bus.outstanding = out_cnt_q;
    assign bus.busy        = (out_cnt_q != '0) | (skid_cnt_q != 2'd0) | dn_valid | ~st_idle;

endmodule

`default_nettype wire

// File: tb/tb_shared_resource_client.sv
// ============================================================================
// tb_shared_resource_client : directed + random bench with queue model Rev 1.0
// ============================================================================
`default_nettype none

module tb_shared_resource_client;
    localparam int DW   = 32;
    localparam int MAXO = 4;
    localparam int RQD  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    shared_resource_client_if #(.DATA_W(DW), .MAX_OUTSTANDING(MAXO)) bus ();

    shared_resource_client #(.DATA_W(DW), .MAX_OUTSTANDING(MAXO), .RQ_DEPTH(RQD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: queues for skid, result FIFO and the port's pending requests.
    logic [DW-1:0] m_skid [$];
    logic [DW-1:0] m_fifo [$];
    logic [DW-1:0] p_q    [$];
    logic [DW-1:0] req_seen [$];
    logic [DW-1:0] dn_seen  [$];
    int m_out  = 0;
    int m_mode = 0;   // 0 idle, 1 flush, 2 settle
    int peak   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit uv, input logic [DW-1:0] ud, input bit rs,
                         input bit rv, input logic [DW-1:0] rd, input bit dr, input bit fl);
        bus.up_valid  = uv;
        bus.up_data   = ud;
        bus.req_stall = rs;
        bus.rsp_valid = rv;
        bus.rsp_data  = rd;
        bus.dn_ready  = dr;
        bus.flush_req = fl;
    endtask

    task automatic port_rsp(input bit force_v);
        if (p_q.size() > 0 && (force_v || $urandom_range(0, 2) != 0)) begin
            bus.rsp_valid = 1'b1;
            bus.rsp_data  = p_q[0] ^ 32'h5A5A_5A5A;
        end else begin
            bus.rsp_valid = 1'b0;
            bus.rsp_data  = '0;
        end
    endtask

    task automatic model_clear();
        m_skid.delete();
        m_fifo.delete();
        p_q.delete();
        m_out  = 0;
        m_mode = 0;
    endtask

    // One clock: compare every output against the model, then advance the model.
    task automatic cycle();
        bit idle, e_upr, e_rv, e_rs, e_dv, issue, push, acc, take, pop;
        #1;
        idle  = (m_mode == 0);
        e_upr = idle && m_skid.size() < 2 && !bus.flush_req;
        e_rv  = idle && m_skid.size() > 0 && m_out < MAXO;
        e_rs  = idle && m_fifo.size() == RQD;
        e_dv  = m_fifo.size() > 0;
        check("up_ready", bus.up_ready, e_upr);
        check("req_valid", bus.req_valid, e_rv);
        if (e_rv) check("req_data", bus.req_data, m_skid[0]);
        check("req_flush", bus.req_flush, m_mode == 1);
        check("rsp_stall", bus.rsp_stall, e_rs);
        check("dn_valid", bus.dn_valid, e_dv);
        if (e_dv) check("dn_data", bus.dn_data, m_fifo[0]);
        check("outstanding", bus.outstanding, m_out);
        check("busy", bus.busy, m_out != 0 || m_skid.size() != 0 || m_fifo.size() != 0 || m_mode != 0);
        if (int'(bus.outstanding) > peak) peak = int'(bus.outstanding);
        if (bus.req_valid && !bus.req_stall) req_seen.push_back(bus.req_data);
        if (bus.dn_valid && bus.dn_ready) dn_seen.push_back(bus.dn_data);
        issue = e_rv && !bus.req_stall;
        push  = bus.up_valid && e_upr;
        take  = bus.rsp_valid && !e_rs;
        acc   = take && idle;
        pop   = e_dv && bus.dn_ready;
        @(posedge clk);
        if (take && p_q.size() > 0) void'(p_q.pop_front());
        if (issue) p_q.push_back(m_skid.pop_front());
        if (push) m_skid.push_back(bus.up_data);
        if (pop) void'(m_fifo.pop_front());
        if (acc && m_out > 0) begin
            m_fifo.push_back(bus.rsp_data);
            m_out--;
        end
        if (issue) m_out++;
        if (m_mode == 1) begin
            m_skid.delete();
            m_fifo.delete();
            p_q.delete();
            m_out = 0;
        end
        m_mode = bus.flush_req ? 1 : (m_mode == 1 ? 2 : 0);
        #1;
    endtask

    task automatic drain(input int n, input bit dr);
        for (int i = 0; i < n; i++) begin
            drive(0, '0, 0, 0, '0, dr, 0);
            port_rsp(1);
            cycle();
        end
    endtask

    initial begin
        drive(0, '0, 0, 0, '0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_up_ready", bus.up_ready, 1);
        check("rst_req_valid", bus.req_valid, 0);
        check("rst_busy", bus.busy, 0);
        reset = 1'b0;
        model_clear();

        // Basic in-order flow, responses two cycles after each issue.
        peak = 0;
        req_seen.delete();
        dn_seen.delete();
        drive(1, 32'h11, 0, 0, '0, 1, 0); cycle();
        drive(1, 32'h22, 0, 0, '0, 1, 0); cycle();
        drive(1, 32'h33, 0, 0, '0, 1, 0); cycle();
        drive(0, '0, 0, 1, 32'hA1, 1, 0); cycle();
        drive(0, '0, 0, 1, 32'hA2, 1, 0); cycle();
        drive(0, '0, 0, 1, 32'hA3, 1, 0); cycle();
        drive(0, '0, 0, 0, '0, 1, 0); cycle(); cycle();
        check("t1_req_cnt", req_seen.size(), 3);
        check("t1_req0", req_seen[0], 32'h11);
        check("t1_req2", req_seen[2], 32'h33);
        check("t1_dn_cnt", dn_seen.size(), 3);
        check("t1_dn0", dn_seen[0], 32'hA1);
        check("t1_dn2", dn_seen[2], 32'hA3);
        check("t1_peak", peak, 2);
        #1;
        check("t1_busy_end", bus.busy, 0);

        // Port stall held five cycles while three ops arrive.
        req_seen.delete();
        drive(1, 32'hB1, 1, 0, '0, 1, 0); cycle();
        drive(1, 32'hB2, 1, 0, '0, 1, 0); cycle();
        drive(1, 32'hB3, 1, 0, '0, 1, 0);
        #1;
        check("t2_up_ready_full", bus.up_ready, 0);
        check("t2_req_data_hold", bus.req_data, 32'hB1);
        cycle(); cycle(); cycle();
        drive(1, 32'hB3, 0, 0, '0, 1, 0); cycle(); cycle();
        drain(10, 1);
        check("t2_req_cnt", req_seen.size(), 3);
        check("t2_req1", req_seen[1], 32'hB2);
        check("t2_req2", req_seen[2], 32'hB3);

        // Outstanding limit.
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'hC0 + i, 0, 0, '0, 1, 0);
            cycle();
        end
        drive(0, '0, 0, 0, '0, 1, 0); cycle();
        #1;
        check("t3_req_valid_lim", bus.req_valid, 0);
        check("t3_out_max", bus.outstanding, 4);
        drive(0, '0, 0, 0, '0, 1, 0);
        port_rsp(1);
        cycle();
        drive(0, '0, 0, 0, '0, 1, 0);
        #1;
        check("t3_req_valid_5th", bus.req_valid, 1);
        check("t3_req_data_5th", bus.req_data, 32'hC4);
        drain(10, 1);

        // Result FIFO full backpressure.
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'hD0 + i, 0, 0, '0, 0, 0);
            port_rsp(1);
            cycle();
        end
        drain(12, 0);
        #1;
        check("t4_rsp_stall_full", bus.rsp_stall, 1);
        check("t4_out_held", bus.outstanding, 1);
        drive(0, '0, 0, 0, '0, 1, 0);
        port_rsp(1);
        cycle();
        drive(0, '0, 0, 0, '0, 0, 0);
        port_rsp(1);
        #1;
        check("t4_rsp_stall_low", bus.rsp_stall, 0);
        cycle();
        check("t4_out_zero", bus.outstanding, 0);
        drain(8, 1);

        // Flush with skid, outstanding and FIFO all occupied.
        drive(1, 32'hE0, 0, 0, '0, 0, 0); cycle();
        drive(0, '0, 0, 0, '0, 0, 0); cycle();
        port_rsp(1); cycle();
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'hF0 + i, 0, 0, '0, 0, 0);
            cycle();
        end
        drive(0, '0, 1, 0, '0, 0, 0);
        port_rsp(1);
        cycle();
        check("t5_out_pre", bus.outstanding, 3);
        drive(1, 32'h99, 1, 0, '0, 0, 1);
        #1;
        check("t5_up_ready_flushreq", bus.up_ready, 0);
        cycle();
        drive(0, '0, 0, 0, '0, 0, 0);
        #1;
        check("t5_req_flush", bus.req_flush, 1);
        cycle();
        drive(0, '0, 0, 1, 32'hDEAD, 0, 0);
        #1;
        check("t5_out_cleared", bus.outstanding, 0);
        check("t5_dn_valid_cleared", bus.dn_valid, 0);
        check("t5_req_flush_once", bus.req_flush, 0);
        cycle();
        drive(0, '0, 0, 0, '0, 0, 0);
        #1;
        check("t5_up_ready_back", bus.up_ready, 1);
        check("t5_busy_idle", bus.busy, 0);
        cycle();

        // Response with nothing outstanding is dropped.
        drive(0, '0, 0, 1, 32'h77, 1, 0); cycle();
        drive(0, '0, 0, 0, '0, 1, 0);
        #1;
        check("drop_dn_valid", bus.dn_valid, 0);
        check("drop_out", bus.outstanding, 0);
        cycle();

        // Randomised traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 1), $urandom(), $urandom_range(0, 3) == 0, 0, '0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 59) == 0);
            port_rsp(0);
            cycle();
        end
        drive(0, '0, 0, 0, '0, 1, 0);
        cycle(); cycle(); cycle();
        drain(12, 1);

        // Asynchronous reset between edges with every queue occupied.
        for (int i = 0; i < 6; i++) begin
            drive(1, 32'h100 + i, 0, 0, '0, 0, 0);
            port_rsp(1);
            cycle();
        end
        drive(1, 32'h200, 1, 0, '0, 0, 0); cycle();
        drive(1, 32'h201, 1, 0, '0, 0, 0); cycle();
        drive(0, '0, 0, 0, '0, 0, 0);
        check("t6_busy_pre", bus.busy, 1);
        check("t6_dn_valid_pre", bus.dn_valid, 1);
        #3;
        reset = 1'b1;
        #1;
        check("t6_up_ready", bus.up_ready, 1);
        check("t6_req_valid", bus.req_valid, 0);
        check("t6_req_data", bus.req_data, 0);
        check("t6_req_flush", bus.req_flush, 0);
        check("t6_rsp_stall", bus.rsp_stall, 0);
        check("t6_dn_valid", bus.dn_valid, 0);
        check("t6_dn_data", bus.dn_data, 0);
        check("t6_outstanding", bus.outstanding, 0);
        check("t6_busy", bus.busy, 0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        drive(1, 32'h300, 0, 0, '0, 1, 0); cycle();
        drive(0, '0, 0, 0, '0, 1, 0); cycle();
        drain(6, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
